// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Multiply uses shift-add, retiring MUL_STEP multiplier bits per cycle. Divide uses restoring
// division, one quotient bit per cycle. Both work on operand magnitudes and apply the sign in FIX.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam int unsigned MulIters = WIDTH / MUL_STEP;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               qneg_q, qneg_d;   // product / quotient negate
  logic               rneg_q, rneg_d;   // remainder negate (sign of dividend)
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {product hi, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;

  logic [WIDTH+MUL_STEP-1:0] partial, mul_sum;
  logic [2*WIDTH-1:0]        mul_acc, div_acc, prod;
  logic [WIDTH:0]            div_shift, div_diff;
  logic [WIDTH-1:0]          quo, rem, fix_res;

  // Operand decode: signedness per op, magnitudes and divide special cases.
  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    sa       = a_signed & a[WIDTH-1];
    sb       = b_signed & b[WIDTH-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    div_zero = (b == '0);
    div_ovf  = ~funct3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  end

  // One multiply step: add multiplicand * low digit into the high half, then shift right.
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc_q[i]) partial = partial + ((WIDTH+MUL_STEP)'(opnd_q) << i);
    end
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
    mul_acc = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) div_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else                 div_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up and result select used in the FIX state.
  always_comb begin
    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!op_q[2]) fix_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else          fix_res = op_q[1] ? rem : quo;
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d   = funct3;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          if (!funct3[2]) begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            opnd_d  = a_mag;
            cnt_d   = CW'(MulIters);
            state_d = StMul;
          end else if (div_zero) begin
            result_d = funct3[1] ? a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            state_d  = StDone;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = b_mag;
            cnt_d   = CW'(WIDTH);
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort: drop the op without touching the visible result.
    if (flush && state_q != StIdle) begin
      state_d  = StIdle;
      result_d = result_q;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign ready  = ~busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: two instances (MUL_STEP 1 and 4), a driver that pushes
// expected results/latencies on accept, and per-instance monitors that pop on every done pulse.
`timescale 1ns/1ps
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        start0, ready0, busy0, done0;
  logic        start1, ready1, busy1, done1;
  logic [31:0] result0, result1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ndone0 = 0;
  int   ndone1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [31:0] last_res0 = '0;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .funct3(funct3), .a(a), .b(b), .flush(flush),
    .ready(ready0), .busy(busy0), .done(done0), .result(result0)
  );

  muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .funct3(funct3), .a(a), .b(b), .flush(flush),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic fail_event(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference model: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    int              xi, yi;
    longint          p;
    longint unsigned ux, uy, pu;
    xi = x;
    yi = y;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      3'd0: begin pu = ux * uy; return pu[31:0]; end
      3'd1: begin p = longint'(xi) * longint'(yi); return p[63:32]; end
      3'd2: begin p = longint'(xi) * longint'(uy); return p[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(xi / yi);
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(xi % yi);
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int exp_lat(input int d, input logic [2:0] f, input logic [31:0] x,
                                 input logic [31:0] y);
    if (!f[2]) return 32 / ((d == 0) ? 1 : 4) + 2;
    if (y == 32'd0) return 1;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Wait for ready, present one op for one accept edge, optionally record the expectation.
  task automatic issue(input int d, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] want, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!((d == 0) ? ready0 : ready1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!((d == 0) ? ready0 : ready1)) begin
      fail_event("ready_timeout");
      return;
    end
    funct3 = f;
    a      = x;
    b      = y;
    if (d == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      e.res = want;
      e.lat = exp_lat(d, f, x, y);
      e.acc = cyc;
      if (d == 0) begin
        q0.push_back(e);
        last_res0 = want;
      end else begin
        q1.push_back(e);
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (n < 400 && !((d == 0) ? (q0.size() == 0 && ready0) : (q1.size() == 0 && ready1))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_event("idle_timeout");
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done0) begin
      ndone0++;
      if (q0.size() == 0) begin
        fail_event("unexpected_done0");
      end else begin
        e0 = q0.pop_front();
        chk("result0", result0, e0.res);
        chk("latency0", 32'(cyc - e0.acc + 1), 32'(e0.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      ndone1++;
      if (q1.size() == 0) begin
        fail_event("unexpected_done1");
      end else begin
        e1 = q1.pop_front();
        chk("result1", result1, e1.res);
        chk("latency1", 32'(cyc - e1.acc + 1), 32'(e1.lat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    int          nd, n;

    rst = 1'b0; flush = 1'b0; start0 = 1'b0; start1 = 1'b0;
    funct3 = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_ready0", ready0, 1); chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);   chk("rst_result0", result0, 0);
    chk("rst_ready1", ready1, 1); chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);   chk("rst_result1", result1, 0);

    // Directed multiplies and divides on the MUL_STEP=1 instance
    issue(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue(0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    issue(0, 3'b111, 32'd100, 32'd7, 32'd2, 1'b1);

    // Flush mid-divide: no done, result keeps its previous value
    wait_idle(0);
    issue(0, 3'b100, 32'd1234567, 32'd3, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", ready0, 1);
    chk("flush_busy", busy0, 0);
    chk("flush_result", result0, last_res0);
    nd = ndone0;
    repeat (40) @(negedge clk);
    chk("flush_no_done", 32'(ndone0), 32'(nd));

    // start together with flush in idle is not accepted
    funct3 = 3'b101; a = 32'd9; b = 32'd2; start0 = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_start_busy", busy0, 0);
    chk("flush_start_ready", ready0, 1);
    @(negedge clk);
    start0 = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_start_no_done", 32'(ndone0), 32'(nd));

    // Special-case divides complete in one cycle
    issue(0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(0, 3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Start held high with changing operands, then back-to-back accept after done
    wait_idle(0);
    @(negedge clk);
    funct3 = 3'b011; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start0 = 1'b1;
    @(posedge clk);
    #1;
    e0.res = model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    e0.lat = 34;
    e0.acc = cyc;
    q0.push_back(e0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done0) begin
        a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
    end while (!done0 && n < 100);
    if (!done0) fail_event("held_start_timeout");
    funct3 = 3'b101; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    chk("b2b_ready", ready0, 1);
    @(posedge clk);
    #1;
    chk("b2b_accept_busy", busy0, 1);
    e0.res = 32'd142;
    e0.lat = 34;
    e0.acc = cyc;
    q0.push_back(e0);
    @(negedge clk);
    start0 = 1'b0;

    // Directed multiplies on the MUL_STEP=4 instance
    issue(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    issue(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);

    // Randomized traffic with biased special cases
    for (int i = 0; i < 160; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(0, 15)); end
        3: begin x = -32'($urandom_range(0, 255)); y = -32'($urandom_range(1, 15)); end
        default: ;
      endcase
      issue((i % 4 == 3) ? 1 : 0, f, x, y, model(f, x, y), 1'b1);
    end

    // Asynchronous reset in the middle of a divide
    wait_idle(0);
    wait_idle(1);
    issue(0, 3'b100, 32'h0765_4321, 32'd3, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", ready0, 1);
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    chk("arst_result", result0, 0);
    nd = ndone0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_done", 32'(ndone0), 32'(nd));

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit, parametrised in datapath width and multiply throughput.
- Sits beside the ALU in EX and is driven by the decoded control word: funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Uses a start/done handshake; the pipeline stalls on busy.
- Covers the full M extension, including div-by-zero and signed-overflow rules, with flush abort.

Parameters:
- WIDTH, 32, operand/result width in bits; even, >= 8.
- MUL_STEP, 1, multiplier bits retired per cycle; one of 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only when ready=1.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- flush  in  1  abort in-flight op (branch mispredict / pipeline flush).
- ready  out  1  idle, can accept start.
- busy  out  1  op in flight; stall EX.
- done  out  1  single-cycle pulse, result valid.
- result  out  WIDTH  result; held stable until the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, busy=0, done=0, result=0, all internal registers cleared. Reset mid-operation discards the op with no done.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start=1 and flush=0 latches funct3, a and b, then:
  - multiply ops go to MUL;
  - divide ops with b==0, or signed overflow (a==2^(WIDTH-1), b==all-ones, DIV/REM only), go to DONE;
  - all other divide ops go to DIV.
- Signedness:
  - MUL: unsigned (low half is sign-agnostic).
  - MULH: a signed, b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
  - Signed operands are converted to magnitude at latch; the negate flag is stored.
- MUL state: shift-add on the 2*WIDTH product, MUL_STEP multiplier bits per cycle, a step counter of WIDTH/MUL_STEP iterations, then FIX.
- DIV state: restoring division, 1 quotient bit per cycle, WIDTH iterations, then FIX.
- FIX state (1 cycle):
  - Multiply: negate the product if the operand signs differ. Result = low WIDTH bits for MUL, high WIDTH bits otherwise.
  - Divide: quotient sign = sa^sb; remainder sign = sa. Result = quotient (DIV/DIVU) or remainder (REM/REMU).
- Special results (written when entering DONE):
  - Div-by-zero: DIV/DIVU -> all-ones; REM/REMU -> a.
  - Signed overflow: DIV -> 2^(WIDTH-1); REM -> 0.
- DONE state: done=1 for exactly one cycle, result updated on the same edge, then IDLE (ready=1 in the following cycle). Back-to-back start is accepted the cycle after done.
- Latency, counted from the accept edge to the cycle with done=1:
  - multiply: WIDTH/MUL_STEP+2 (34 for defaults);
  - normal divide: WIDTH+2 (34);
  - special-case divide: 1.
- busy=1 in MUL, DIV, FIX and DONE; ready = ~busy.
- start while busy: ignored; latched operands are unaffected.
- flush=1 in any non-IDLE state: next edge goes to IDLE, no done pulse, result unchanged.
- flush and start in the same cycle in IDLE: flush wins, nothing accepted.
- flush in DONE: done still deasserts next cycle, and result is NOT updated (the update occurs on the DONE entry edge, which is suppressed if flush was high in the prior cycle).
- Operand inputs may change freely after the accept edge.

Test Plan:
- Reset (rst=0), then release: ready=1, busy=0, done=0, result=0. Then MUL a=7, b=-3 (0xFFFFFFFD): done after 34 cycles, result=0xFFFFFFEB.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF. Repeat all three with MUL_STEP=4: latency 10, same results.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2. Each has latency 34.
- Special cases: DIVU a=5, b=0 -> done after 1 cycle, result 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000 in 1 cycle. REM with the same operands -> 0.
- Flush: start DIV, flush at cycle 10 -> ready=1 next cycle, no done, result keeps its prior value. Then start=1 with flush=1 in IDLE -> not accepted, busy stays 0.
- start held high during a multiply with different a/b values -> result matches the first latched operands. A second start issued the cycle after done is accepted.
- Async reset asserted mid-DIV (between clock edges) -> outputs return to reset values immediately, and no done pulse follows.
